// File: rtl/shapool_result_fifo.sv
// Result FIFO behind the hashing pool: captures nonces on success pulses, pops via valid/ready.
// Optional macro SHAPOOL_RESULT_STAMP_EN adds a 16-bit free-running timestamp per entry.
module shapool_result_fifo #(
  parameter int unsigned NONCE_WIDTH    = 32,
  parameter int unsigned DEPTH_LOG2     = 2,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      success,
  input  logic [NONCE_WIDTH-1:0]    nonce,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NONCE_WIDTH-1:0]    out_nonce,
  output logic [15:0]               out_stamp,
  output logic [DEPTH_LOG2:0]       count,
  output logic                      halt,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned STAMP_W = 16;

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          count_c, count_d;
  logic                      halt_q, halt_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [NONCE_WIDTH-1:0]    nonce_mem_q [DEPTH];

  logic clear_c, full_c, empty_c, pop_c, push_c, drop_c;

  assign clear_c = !reset_n || flush;
  assign count_c = wr_ptr_q - rd_ptr_q;
  assign full_c  = (count_c == PTR_W'(DEPTH));
  assign empty_c = (count_c == '0);
  assign pop_c   = !empty_c && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_c  = success && (!full_c || pop_c);
  assign drop_c  = success && full_c && !pop_c;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = wr_ptr_d - rd_ptr_d;
    halt_d     = (count_d == PTR_W'(DEPTH));
    overflow_d = overflow_q || drop_c;
    drop_d     = drop_q;
    if (drop_c && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_WIDTH'(1);
    end
  end

  // Control state; reset and flush share one synchronous clear.
  always_ff @(posedge clk) begin
    if (clear_c) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      halt_q     <= halt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!clear_c && push_c) begin
      nonce_mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= nonce;
    end
  end

  assign out_valid  = !empty_c;
  assign out_nonce  = empty_c ? '0 : nonce_mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign count      = count_c;
  assign halt       = halt_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

`ifdef SHAPOOL_RESULT_STAMP_EN
  logic [STAMP_W-1:0] stamp_q;
  logic [STAMP_W-1:0] stamp_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clear_c) begin
      stamp_q <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_c && push_c) begin
      stamp_mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= stamp_q;
    end
  end

  assign out_stamp = empty_c ? '0 : stamp_mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
`else
  assign out_stamp = STAMP_W'(0);
`endif

endmodule

// File: tb/tb_shapool_result_fifo.sv
// Directed self-checking bench for shapool_result_fifo (default parameters).
module tb_shapool_result_fifo;

  localparam int unsigned NW = 32;
  localparam int unsigned DL = 2;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          success = 1'b0;
  logic [NW-1:0] nonce = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NW-1:0] out_nonce;
  logic [15:0]   out_stamp;
  logic [DL:0]   count;
  logic          halt;
  logic          overflow;
  logic [DW-1:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;

  always #5 clk = ~clk;

  shapool_result_fifo #(.NONCE_WIDTH(NW), .DEPTH_LOG2(DL), .DROP_CNT_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .success(success), .nonce(nonce),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
    .out_stamp(out_stamp), .count(count), .halt(halt), .overflow(overflow),
    .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    t = 0;
  endtask

  task automatic push(input logic [NW-1:0] v);
    success = 1'b1;
    nonce   = v;
    step();
    success = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [NW-1:0] v);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_nonce"}, 64'(out_nonce), 64'(v));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] stamp_a, stamp_b;
`ifdef SHAPOOL_RESULT_STAMP_EN
    stamp_a = 16'd5;
    stamp_b = 16'd4464;
`else
    stamp_a = 16'd0;
    stamp_b = 16'd0;
`endif

    // Reset then idle
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_nonce", 64'(out_nonce), 64'd0);
    check("rst_stamp", 64'(out_stamp), 64'd0);

    // Timestamps at cycle 5 and cycle 70000 after reset release
    repeat (5) step();
    push(32'h11);
    check("stamp5_valid", 64'(out_valid), 64'd1);
    check("stamp5", 64'(out_stamp), 64'(stamp_a));
    pop_expect("stamp5_pop", 32'h11);
    repeat (70000 - t) step();
    push(32'h22);
    check("stamp70000", 64'(out_stamp), 64'(stamp_b));
    pop_expect("stamp70000_pop", 32'h22);
    check("stamp_empty", 64'(out_stamp), 64'd0);

    // Single capture with held head
    do_reset();
    push(32'h0ABCDEF1);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_nonce", 64'(out_nonce), 64'h0ABCDEF1);
    check("single_count", 64'(count), 64'd1);
    out_ready = 1'b0;
    repeat (3) step();
    check("single_hold_nonce", 64'(out_nonce), 64'h0ABCDEF1);
    check("single_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_popped_valid", 64'(out_valid), 64'd0);
    check("single_popped_nonce", 64'(out_nonce), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_ready_count", 64'(count), 64'd0);

    // Fill and overflow
    for (int i = 1; i <= 6; i++) begin
      push(NW'(i));
      if (i == 3) check("fill3_halt", 64'(halt), 64'd0);
      if (i == 4) begin
        check("fill4_halt", 64'(halt), 64'd1);
        check("fill4_count", 64'(count), 64'd4);
        check("fill4_ovf", 64'(overflow), 64'd0);
      end
    end
    check("fill_ovf", 64'(overflow), 64'd1);
    check("fill_drop", 64'(drop_count), 64'd2);
    check("fill_count", 64'(count), 64'd4);
    pop_expect("fill_pop1", 32'd1);
    check("fill_halt_fall", 64'(halt), 64'd0);
    check("fill_count3", 64'(count), 64'd3);
    pop_expect("fill_pop2", 32'd2);
    pop_expect("fill_pop3", 32'd3);
    pop_expect("fill_pop4", 32'd4);
    check("fill_empty", 64'(out_valid), 64'd0);
    check("fill_ovf_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 4; i++) push(NW'(i));
    check("fullpp_halt0", 64'(halt), 64'd1);
    success   = 1'b1;
    nonce     = 32'd7;
    out_ready = 1'b1;
    step();
    success   = 1'b0;
    out_ready = 1'b0;
    check("fullpp_count", 64'(count), 64'd4);
    check("fullpp_drop", 64'(drop_count), 64'd0);
    check("fullpp_ovf", 64'(overflow), 64'd0);
    check("fullpp_halt", 64'(halt), 64'd1);
    pop_expect("fullpp_pop1", 32'd2);
    pop_expect("fullpp_pop2", 32'd3);
    pop_expect("fullpp_pop3", 32'd4);
    pop_expect("fullpp_pop4", 32'd7);
    check("fullpp_empty", 64'(count), 64'd0);

    // Flush mid-operation with pending push and pop
    for (int i = 1; i <= 5; i++) push(NW'(i + 8));
    pop_expect("flush_pre_pop", 32'd9);
    check("flush_pre_count", 64'(count), 64'd3);
    check("flush_pre_ovf", 64'(overflow), 64'd1);
    flush     = 1'b1;
    success   = 1'b1;
    nonce     = 32'hDEAD;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    success   = 1'b0;
    out_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ovf", 64'(overflow), 64'd0);
    check("flush_drop", 64'(drop_count), 64'd0);
    check("flush_halt", 64'(halt), 64'd0);
    check("flush_nonce", 64'(out_nonce), 64'd0);
    step();
    check("flush_no_capture", 64'(count), 64'd0);

    // Drop counter saturation
    for (int i = 1; i <= 4; i++) push(NW'(i));
    success = 1'b1;
    repeat (300) step();
    success = 1'b0;
    check("sat_drop", 64'(drop_count), 64'hFF);
    check("sat_count", 64'(count), 64'd4);
    pop_expect("sat_pop1", 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
